// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for a small
// RV32 subset, with a bounded wait on every memory request.
module multicycle_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   input  logic        alu_zero,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic [31:0] ir,
   output logic        pc_write,
   output logic        pc_src,
   output logic [3:0]  alu_sel,
   output logic        alu_src,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        illegal,
   output logic        bus_err,
   output logic        retire,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLL  = 4'b0010;
   localparam logic [3:0] ALU_SLT  = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      st_q, st_d;
   logic [31:0] ir_q, ir_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        gap_q, gap_d;

   logic [6:0] opc, f7;
   logic [2:0] f3;
   logic       is_r, is_i, is_ld, is_st, is_br;
   logic       legal, taken, tmo;
   logic [3:0] f3_sel, ex_sel;
   logic       ex_src;

   assign opc   = ir_q[6:0];
   assign f3    = ir_q[14:12];
   assign f7    = ir_q[31:25];
   assign is_r  = (opc == OP_R);
   assign is_i  = (opc == OP_I);
   assign is_ld = (opc == OP_LD);
   assign is_st = (opc == OP_ST);
   assign is_br = (opc == OP_BR);

   assign legal = (is_r && !(f3 == 3'b000 && f7 != 7'b0000000
                             && f7 != 7'b0100000))
                || is_i || is_ld || is_st
                || (is_br && f3[2:1] == 2'b00);

   assign taken = (f3 == 3'b000 && alu_zero)
                || (f3 == 3'b001 && !alu_zero);

   assign tmo = !mem_ack && (cnt_q == TMO_LAST);

   always_comb begin
      f3_sel = ALU_ADD;
      unique case (f3)
         3'b000: f3_sel = ALU_ADD;
         3'b001: f3_sel = ALU_SLL;
         3'b010: f3_sel = ALU_SLT;
         3'b011: f3_sel = ALU_SLTU;
         3'b100: f3_sel = ALU_XOR;
         3'b101: f3_sel = ALU_SRL;
         3'b110: f3_sel = ALU_OR;
         3'b111: f3_sel = ALU_AND;
      endcase
   end

   // ALU setup shared by EXEC and WB so WB holds the EXEC values
   always_comb begin
      ex_sel = ALU_ADD;
      ex_src = 1'b1;
      unique case (1'b1)
         is_r: begin
            ex_src = 1'b0;
            ex_sel = (f3 == 3'b000 && f7[5]) ? ALU_SUB : f3_sel;
         end
         is_i:  ex_sel = f3_sel;
         is_br: begin
            ex_sel = ALU_SUB;
            ex_src = 1'b0;
         end
         default: ;
      endcase
   end

   always_comb begin
      st_d         = st_q;
      ir_d         = ir_q;
      cnt_d        = 8'd0;
      gap_d        = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      alu_sel      = ALU_ADD;
      alu_src      = 1'b0;
      reg_write    = 1'b0;
      mem_to_reg   = 1'b0;
      illegal      = 1'b0;
      bus_err      = 1'b0;
      retire       = 1'b0;
      if (!rst) begin
         unique case (st_q)
            S_FETCH: if (!gap_q) begin
               mem_req = 1'b1;
               if (mem_ack) begin
                  ir_d     = mem_rdata;
                  pc_write = 1'b1;
                  st_d     = S_DECODE;
               end else if (tmo) begin
                  bus_err = 1'b1;
                  gap_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            S_DECODE: begin
               illegal = !legal;
               st_d    = legal ? S_EXEC : S_FETCH;
            end
            S_EXEC: begin
               alu_sel = ex_sel;
               alu_src = ex_src;
               unique case (1'b1)
                  is_ld, is_st: st_d = S_MEM;
                  is_br: begin
                     pc_write = taken;
                     pc_src   = taken;
                     retire   = 1'b1;
                     st_d     = S_FETCH;
                  end
                  default: st_d = S_WB;
               endcase
            end
            S_MEM: begin
               mem_req      = 1'b1;
               mem_we       = is_st;
               mem_addr_sel = 1'b1;
               alu_sel      = ALU_ADD;
               alu_src      = 1'b1;
               if (mem_ack) begin
                  retire = is_st;
                  st_d   = is_st ? S_FETCH : S_WB;
               end else if (tmo) begin
                  bus_err = 1'b1;
                  gap_d   = 1'b1;
                  st_d    = S_FETCH;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            S_WB: begin
               alu_sel    = ex_sel;
               alu_src    = ex_src;
               reg_write  = 1'b1;
               retire     = 1'b1;
               mem_to_reg = is_ld;
               st_d       = S_FETCH;
            end
            default: st_d = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q  <= S_FETCH;
         ir_q  <= 32'h0000_0013;
         cnt_q <= 8'd0;
         gap_q <= 1'b0;
      end else begin
         st_q  <= st_d;
         ir_q  <= ir_d;
         cnt_q <= cnt_d;
         gap_q <= gap_d;
      end
   end

   assign ir    = ir_q;
   assign state = st_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-instruction cycle model of the controller,
// directed corner cases followed by randomized instruction streams.
module tb_multicycle_ctrl;

   localparam int T = 4;

   typedef struct packed {
      logic       req, we, asel, pcw, pcs;
      logic [3:0] alu;
      logic       src, rw, m2r, ill, berr, ret;
      logic [2:0] st;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst, mem_ack, alu_zero;
   logic [31:0] mem_rdata;
   logic        mem_req, mem_we, mem_addr_sel, pc_write, pc_src;
   logic [31:0] ir;
   logic [3:0]  alu_sel;
   logic        alu_src, reg_write, mem_to_reg, illegal, bus_err, retire;
   logic [2:0]  state;

   multicycle_ctrl #(.TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .alu_zero(alu_zero), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_sel(mem_addr_sel), .ir(ir), .pc_write(pc_write),
      .pc_src(pc_src), .alu_sel(alu_sel), .alu_src(alu_src),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg),
      .illegal(illegal), .bus_err(bus_err), .retire(retire),
      .state(state)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   obs_t        exp_o;
   logic        gap;
   logic [31:0] ir_exp;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
      end
   endtask

   function automatic obs_t e0(input logic [2:0] s);
      obs_t o;
      o    = '0;
      o.st = s;
      return o;
   endfunction

   // don't-care fields are zeroed according to the expected cycle
   function automatic obs_t observe(input obs_t e);
      obs_t o;
      logic vis;
      vis    = (e.st == 3'd2) || (e.st == 3'd3) || (e.st == 3'd4);
      o.req  = mem_req;
      o.we   = mem_we & e.req;
      o.asel = mem_addr_sel & e.req;
      o.pcw  = pc_write;
      o.pcs  = pc_src & e.pcw;
      o.alu  = vis ? alu_sel : 4'd0;
      o.src  = alu_src & vis;
      o.rw   = reg_write;
      o.m2r  = mem_to_reg & e.rw;
      o.ill  = illegal;
      o.berr = bus_err;
      o.ret  = retire;
      o.st   = state;
      return o;
   endfunction

   task automatic tick(input string tag, input logic ack);
      mem_ack = ack;
      #1;
      chk(tag, 32'(observe(exp_o)), 32'(exp_o));
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] alu_of(input logic [2:0] f);
      case (f)
         3'd0: return 4'd0;
         3'd1: return 4'd2;
         3'd2: return 4'd3;
         3'd3: return 4'd8;
         3'd4: return 4'd4;
         3'd5: return 4'd5;
         3'd6: return 4'd6;
         default: return 4'd7;
      endcase
   endfunction

   // rst_at: 0 none, 1 reset together with the MEM ack, 2 reset in WB
   task automatic run_instr(input logic [31:0] w, input int fw,
                            input int mw, input logic z,
                            input int rst_at);
      logic [6:0] op, f7;
      logic [2:0] f3;
      logic       ok, r, i_t, ld, st, br;
      logic [3:0] xa;
      logic       xs;
      op  = w[6:0];
      f3  = w[14:12];
      f7  = w[31:25];
      r   = op == 7'b0110011;
      i_t = op == 7'b0010011;
      ld  = op == 7'b0000011;
      st  = op == 7'b0100011;
      br  = op == 7'b1100011;
      ok  = i_t || ld || st || (br && (f3 == 3'd0 || f3 == 3'd1))
         || (r && (f3 != 3'd0 || f7 == 7'h00 || f7 == 7'h20));
      alu_zero = z;
      if (gap) begin
         exp_o = e0(3'd0);
         mem_rdata = $urandom;
         tick("gap", 1'($urandom_range(0, 1)));
         gap = 1'b0;
      end
      for (int i = 0; i < fw; i++) begin
         exp_o     = e0(3'd0);
         exp_o.req = 1'b1;
         mem_rdata = $urandom;
         if (i == T - 1) begin
            exp_o.berr = 1'b1;
            tick("fetch_tmo", 1'b0);
            chk("ir_hold", ir, ir_exp);
            gap = 1'b1;
            return;
         end
         tick("fetch_wait", 1'b0);
      end
      exp_o     = e0(3'd0);
      exp_o.req = 1'b1;
      exp_o.pcw = 1'b1;
      mem_rdata = w;
      tick("fetch_ack", 1'b1);
      ir_exp = w;
      chk("ir", ir, w);
      mem_rdata = $urandom;
      exp_o     = e0(3'd1);
      exp_o.ill = !ok;
      tick("decode", 1'($urandom_range(0, 1)));
      if (!ok) return;
      xa = 4'd0;
      xs = 1'b1;
      if (r) begin
         xs = 1'b0;
         xa = (f3 == 3'd0) ? ((f7 == 7'h20) ? 4'd1 : 4'd0) : alu_of(f3);
      end else if (i_t) begin
         xa = alu_of(f3);
      end else if (br) begin
         xa = 4'd1;
         xs = 1'b0;
      end
      exp_o     = e0(3'd2);
      exp_o.alu = xa;
      exp_o.src = xs;
      if (br) begin
         exp_o.ret = 1'b1;
         exp_o.pcw = (f3 == 3'd0) ? z : !z;
         exp_o.pcs = exp_o.pcw;
      end
      tick(br ? "exec_br" : "exec", 1'($urandom_range(0, 1)));
      if (br) return;
      if (ld || st) begin
         for (int i = 0; i <= mw; i++) begin
            exp_o      = e0(3'd3);
            exp_o.req  = 1'b1;
            exp_o.asel = 1'b1;
            exp_o.we   = st;
            exp_o.alu  = 4'd0;
            exp_o.src  = 1'b1;
            if (i < mw) begin
               if (i == T - 1) begin
                  exp_o.berr = 1'b1;
                  tick("mem_tmo", 1'b0);
                  gap = 1'b1;
                  return;
               end
               tick("mem_wait", 1'b0);
            end else if (rst_at == 1) begin
               rst     = 1'b1;
               mem_ack = 1'b1;
               #1;
               chk("rst_mem_strb", {mem_req, pc_write, reg_write,
                   illegal, bus_err, retire}, 0);
               @(posedge clk);
               #1;
               rst = 1'b0;
               chk("rst_mem_state", state, 0);
               return;
            end else begin
               exp_o.ret = st;
               tick("mem_ack", 1'b1);
            end
         end
         if (st) return;
      end
      if (rst_at == 2) begin
         rst     = 1'b1;
         mem_ack = 1'b0;
         #1;
         chk("rst_wb_strb", {reg_write, retire}, 0);
         @(posedge clk);
         #1;
         rst = 1'b0;
         chk("rst_wb_state", state, 0);
         return;
      end
      exp_o     = e0(3'd4);
      exp_o.alu = xa;
      exp_o.src = xs;
      exp_o.rw  = 1'b1;
      exp_o.ret = 1'b1;
      exp_o.m2r = ld;
      tick("wb", 1'($urandom_range(0, 1)));
   endtask

   function automatic logic [31:0] gen();
      logic [31:0] w;
      int k;
      w = $urandom;
      k = $urandom_range(0, 6);
      case (k)
         0: begin
            w[6:0] = 7'b0110011;
            case ($urandom_range(0, 2))
               0: w[31:25] = 7'h00;
               1: w[31:25] = 7'h20;
               default: ;
            endcase
         end
         1: w[6:0] = 7'b0010011;
         2: w[6:0] = 7'b0000011;
         3: w[6:0] = 7'b0100011;
         4: w[6:0] = 7'b1100011;
         5: begin
            w[6:0]   = 7'b1100011;
            w[14:13] = 2'b00;
         end
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      int r;
      rst       = 1'b1;
      mem_ack   = 1'b0;
      alu_zero  = 1'b0;
      mem_rdata = 32'd0;
      gap       = 1'b0;
      ir_exp    = 32'h0000_0013;
      @(posedge clk);
      #1;
      chk("rst_state", state, 0);
      chk("rst_ir", ir, 32'h0000_0013);
      mem_ack = 1'b1;
      #1;
      chk("rst_strb", {mem_req, mem_we, mem_addr_sel, pc_write,
          reg_write, illegal, bus_err, retire}, 0);
      mem_ack = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      run_instr(32'h4020_8033, 2, 0, 1'b0, 0);
      run_instr(32'h0000_A103, 0, 0, 1'b0, 0);
      run_instr(32'h0000_0063, 0, 0, 1'b1, 0);
      run_instr(32'h0000_0063, 0, 0, 1'b0, 0);
      run_instr(32'h0000_1063, 1, 0, 1'b0, 0);
      run_instr(32'hFFFF_FFFF, 0, 0, 1'b0, 0);
      run_instr(32'h0000_2023, 0, T, 1'b0, 0);
      run_instr(32'h0000_2023, 0, T - 1, 1'b0, 0);
      run_instr(32'h0050_0093, T, 0, 1'b0, 0);
      run_instr(32'h0050_0093, 0, 0, 1'b0, 0);
      run_instr(32'h0000_A103, 0, 1, 1'b0, 1);
      run_instr(32'h0000_A103, 0, 0, 1'b0, 2);
      run_instr(32'h0020_C1B3, 0, 0, 1'b0, 0);

      for (int n = 0; n < 300; n++) begin
         int fw, mw;
         r  = $urandom_range(0, 9);
         fw = (r == 9) ? T : r % 3;
         r  = $urandom_range(0, 9);
         mw = (r >= 8) ? r - 4 : r % 4;
         run_instr(gen(), fw, mw, 1'($urandom_range(0, 1)), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
